mem_port_arbiter: RTL and testbench

- Shares the single 256-bit off-chip memory port between two cache-line requesters.
  - Port 0: data cache refill/writeback.
  - Port 1: instruction cache refill, needed once the instruction memory moves behind a cache.
- Sits between the caches and the top-level mem_* interface of the CPU.
- Grants one requester per transaction, latches its request, drives memory until mem_ack_i, then inserts one idle cycle before the next grant.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared cache-line memory port: one transaction per
// grant, request latched at grant time, one idle cycle between grants.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 256,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          // last_q resets to 1 so that port 0 wins the first contended round
          if (p0_req_i && p1_req_i) win = (RR_MODE != 0) ? ~last_q : 1'b0;
          else                      win = p1_req_i;
          write_d = win ? p1_write_i : p0_write_i;
          addr_d  = win ? p1_addr_i  : p0_addr_i;
          data_d  = win ? p1_data_i  : p0_data_i;
          last_d  = win;
          cnt_d   = '0;
          state_d = win ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        if (mem_ack_i)             state_d = GAP;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_enable_o  = (state_q == GRANT0) || (state_q == GRANT1);
  assign mem_write_o   = write_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = data_q;
  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_q;
  assign p0_ack_o      = (state_q == GRANT0) && mem_ack_i;
  assign p1_ack_o      = (state_q == GRANT1) && mem_ack_i;
  assign p0_data_o     = mem_data_i;
  assign p1_data_o     = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         p0_req, p0_wr, p1_req, p1_wr;
  logic [31:0]  p0_addr, p1_addr;
  logic [255:0] p0_wdata, p1_wdata, mem_rdata;
  logic         mem_auto, man_ack, resp_ack;
  logic         mem_ack;
  int           lat, gcnt;

  logic         en[2], wr_o[2], busy[2], err[2], ack0[2], ack1[2];
  logic [31:0]  addr_o[2];
  logic [255:0] wdat_o[2], d0_o[2], d1_o[2];

  int n_checks = 0;
  int n_err = 0;
  int ackq_rr[$];
  int ackq_fp[$];

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  int           m_owner[2], m_wait[2], m_last[2];
  bit           m_gap[2], m_err[2];
  logic         m_wr[2];
  logic [31:0]  m_addr[2];
  logic [255:0] m_data[2];

  assign mem_ack = mem_auto ? resp_ack : man_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(256), .RR_MODE(1), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk_i(clk), .rst_i(rst_n),
    .p0_req_i(p0_req), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_ack_o(ack0[0]), .p0_data_o(d0_o[0]),
    .p1_req_i(p1_req), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_ack_o(ack1[0]), .p1_data_o(d1_o[0]),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .mem_enable_o(en[0]), .mem_write_o(wr_o[0]), .mem_addr_o(addr_o[0]),
    .mem_data_o(wdat_o[0]), .busy_o(busy[0]), .err_timeout_o(err[0]));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(256), .RR_MODE(0), .TIMEOUT_CYCLES(TMO)) u_fp (
    .clk_i(clk), .rst_i(rst_n),
    .p0_req_i(p0_req), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_ack_o(ack0[1]), .p0_data_o(d0_o[1]),
    .p1_req_i(p1_req), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_ack_o(ack1[1]), .p1_data_o(d1_o[1]),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .mem_enable_o(en[1]), .mem_write_o(wr_o[1]), .mem_addr_o(addr_o[1]),
    .mem_data_o(wdat_o[1]), .busy_o(busy[1]), .err_timeout_o(err[1]));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(int k, logic r0, logic r1, int last);
    if (r0 && r1) return (k == 0) ? 1 - last : 0;
    return r0 ? 0 : 1;
  endfunction

  // Transaction-level model: who owns the port, whether we are in the gap cycle
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_owner[k] <= -1; m_gap[k] <= 1'b0; m_last[k] <= 1; m_wait[k] <= 0;
        m_err[k] <= 1'b0; m_wr[k] <= 1'b0; m_addr[k] <= '0; m_data[k] <= '0;
      end else if (m_gap[k]) begin
        m_gap[k] <= 1'b0;
      end else if (m_owner[k] >= 0) begin
        if (mem_ack) begin
          m_owner[k] <= -1;
          m_gap[k]   <= 1'b1;
        end else begin
          m_wait[k] <= (m_wait[k] < TMO) ? m_wait[k] + 1 : TMO;
          if (m_wait[k] + 1 >= TMO) m_err[k] <= 1'b1;
        end
      end else if (p0_req || p1_req) begin
        m_owner[k] <= pick(k, p0_req, p1_req, m_last[k]);
        m_last[k]  <= pick(k, p0_req, p1_req, m_last[k]);
        m_wait[k]  <= 0;
        m_wr[k]    <= (pick(k, p0_req, p1_req, m_last[k]) == 0) ? p0_wr    : p1_wr;
        m_addr[k]  <= (pick(k, p0_req, p1_req, m_last[k]) == 0) ? p0_addr  : p1_addr;
        m_data[k]  <= (pick(k, p0_req, p1_req, m_last[k]) == 0) ? p0_wdata : p1_wdata;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("dut%0d rst en", k), en[k], 1'b0);
        chk($sformatf("dut%0d rst busy", k), busy[k], 1'b0);
        chk($sformatf("dut%0d rst acks", k), {ack0[k], ack1[k]}, 2'b00);
        chk($sformatf("dut%0d rst err", k), err[k], 1'b0);
        chk($sformatf("dut%0d rst addr", k), addr_o[k], 32'h0);
      end else begin
        chk($sformatf("dut%0d en", k), en[k], m_owner[k] >= 0);
        chk($sformatf("dut%0d busy", k), busy[k], (m_owner[k] >= 0) || m_gap[k]);
        chk($sformatf("dut%0d ack0", k), ack0[k], (m_owner[k] == 0) && mem_ack);
        chk($sformatf("dut%0d ack1", k), ack1[k], (m_owner[k] == 1) && mem_ack);
        chk($sformatf("dut%0d err", k), err[k], m_err[k]);
        if (m_owner[k] >= 0) begin
          chk($sformatf("dut%0d write", k), wr_o[k], m_wr[k]);
          chk($sformatf("dut%0d addr", k), addr_o[k], m_addr[k]);
          chk($sformatf("dut%0d wdata", k), wdat_o[k], m_data[k]);
          if (mem_ack) chk($sformatf("dut%0d rdata", k),
                           (m_owner[k] == 0) ? d0_o[k] : d1_o[k], mem_rdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack0[0]) ackq_rr.push_back(0);
      if (ack1[0]) ackq_rr.push_back(1);
      if (ack0[1]) ackq_fp.push_back(0);
      if (ack1[1]) ackq_fp.push_back(1);
    end
  end

  // Memory responder: acks in the (lat+1)th enabled cycle of the round-robin instance
  always @(posedge clk) begin
    #1;
    mem_rdata = {8{$urandom}};
    if (!rst_n || !en[0]) begin
      resp_ack = 1'b0;
      gcnt = 0;
    end else if (gcnt == lat) begin
      resp_ack = 1'b1;
      gcnt = 0;
    end else begin
      resp_ack = 1'b0;
      gcnt++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p0_wr = 1'b0; p1_wr = 1'b0;
    man_ack = 1'b0; mem_auto = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p0_wr = 1'b0; p1_wr = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    mem_rdata = '0; resp_ack = 1'b0; gcnt = 0;
    mem_auto = 1'b0; man_ack = 1'b0; lat = 2;
    repeat (3) tick();
    #1;
    chk("reset enable", en[0], 1'b0);
    chk("reset busy", busy[0], 1'b0);
    rst_n = 1'b1;

    // single read from port 0
    tick(); p0_req = 1'b1; p0_addr = 32'h0000_0100; p0_wr = 1'b0;
    tick(); #1;
    chk("read enable c2", en[0], 1'b1);
    chk("read addr c2", addr_o[0], 32'h100);
    chk("read write c2", wr_o[0], 1'b0);
    for (int c = 3; c <= 11; c++) begin
      tick(); #1;
      chk("read enable hold", en[0], 1'b1);
    end
    tick(); man_ack = 1'b1; #1;
    chk("read p0 ack", ack0[0], 1'b1);
    chk("read p0 data", d0_o[0], mem_rdata);
    chk("read p1 no ack", ack1[0], 1'b0);
    tick(); man_ack = 1'b0; p0_req = 1'b0; #1;
    chk("read gap enable", en[0], 1'b0);
    chk("read gap busy", busy[0], 1'b1);
    tick(); #1;
    chk("read idle busy", busy[0], 1'b0);

    // spurious ack while idle
    man_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      chk("spurious ack", {ack0[0], ack1[0], ack0[1], ack1[1]}, 4'b0000);
    end
    man_ack = 1'b0;

    // both ports requesting continuously: rr alternates, fixed stays on port 0
    do_reset();
    ackq_rr.delete(); ackq_fp.delete();
    mem_auto = 1'b1; lat = 2;
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h1000; p1_addr = 32'h2000;
    repeat (15) tick();
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (12) tick();
    mem_auto = 1'b0;
    chk("rr ack count", ackq_rr.size(), 3);
    chk("fp ack count", ackq_fp.size(), 3);
    if (ackq_rr.size() >= 3) chk("rr order", {ackq_rr[0][1:0], ackq_rr[1][1:0], ackq_rr[2][1:0]}, 6'b00_01_00);
    if (ackq_fp.size() >= 3) chk("fp order", {ackq_fp[0][1:0], ackq_fp[1][1:0], ackq_fp[2][1:0]}, 6'b00_00_00);

    // port 1 write with its inputs changing mid-grant
    do_reset();
    tick(); p1_req = 1'b1; p1_wr = 1'b1; p1_addr = 32'h200; p1_wdata = {32{8'hA5}};
    tick(); p1_addr = 32'h300; p1_wdata = '0; p1_wr = 1'b0; #1;
    chk("write enable", en[0], 1'b1);
    chk("write flag", wr_o[0], 1'b1);
    chk("write addr", addr_o[0], 32'h200);
    chk("write data", wdat_o[0], {32{8'hA5}});
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("write addr hold", addr_o[0], 32'h200);
      chk("write data hold", wdat_o[0], {32{8'hA5}});
    end
    tick(); man_ack = 1'b1; #1;
    chk("write p1 ack", ack1[0], 1'b1);
    chk("write p0 no ack", ack0[0], 1'b0);
    tick(); man_ack = 1'b0; p1_req = 1'b0;
    tick();

    // timeout after the 8th grant cycle, sticky until reset
    do_reset();
    tick(); p0_req = 1'b1; p0_addr = 32'h40;
    tick();
    for (int g = 1; g <= 8; g++) begin
      #1; chk("timeout early", err[0], 1'b0);
      tick();
    end
    #1; chk("timeout set", err[0], 1'b1);
    tick();
    tick(); man_ack = 1'b1; #1;
    chk("timeout late ack", ack0[0], 1'b1);
    chk("timeout held at ack", err[0], 1'b1);
    tick(); man_ack = 1'b0; p0_req = 1'b0; #1;
    chk("timeout gap", en[0], 1'b0);
    tick(); tick(); #1;
    chk("timeout sticky", err[0], 1'b1);
    rst_n = 1'b0; #1;
    chk("timeout cleared by reset", err[0], 1'b0);

    // asynchronous reset during a port 1 grant
    tick(); rst_n = 1'b1;
    tick(); p1_req = 1'b1; p1_addr = 32'h500;
    tick(); #1;
    chk("pre-reset grant", en[0], 1'b1);
    tick(); #1;
    rst_n = 1'b0; #1;
    chk("async rst enable", en[0], 1'b0);
    chk("async rst busy", busy[0], 1'b0);
    chk("async rst no ack", ack1[0], 1'b0);
    tick(); tick(); rst_n = 1'b1;
    tick(); #1;
    chk("regrant enable", en[0], 1'b1);
    chk("regrant addr", addr_o[0], 32'h500);
    tick(); man_ack = 1'b1; #1;
    chk("regrant p1 ack", ack1[0], 1'b1);
    tick(); man_ack = 1'b0; p1_req = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
